// File: rtl/sng_rr_scheduler.sv
// Round-robin scheduler sharing one combinational Weyl SNG among NREQ
// requesters. The accepted sample is converted to a BITSTREAM-bit stream,
// tagged with its requester index and ones-count, and held in a single-entry
// output register.

// Combinational Weyl stochastic number generator.
// A signed QUANT-bit sample is offset to unsigned and scaled (rounded) to a
// ones-count s. Bits BASE + k*STRIDE (mod BITSTREAM) are then set for k < s.
module sng_weyl #(
    parameter int BITSTREAM = 64,
    parameter int BASE      = 2,
    parameter int STRIDE    = 17,
    parameter int QUANT     = 8
) (
    input  logic [QUANT-1:0]           sample,
    output logic [BITSTREAM-1:0]       bits,
    output logic [$clog2(BITSTREAM):0] ones
);
    localparam int BW = $clog2(BITSTREAM);
    localparam int OW = BW + 1;
    // Holds u*BITSTREAM plus the rounding term without overflow.
    localparam int PW = QUANT + OW;

    logic [QUANT-1:0] u;
    logic [PW-1:0]    prod;

    // Offset-binary conversion, then round(u * BITSTREAM / 2^QUANT).
    always_comb begin
        u    = {~sample[QUANT-1], sample[QUANT-2:0]};
        prod = PW'(u) * PW'(BITSTREAM) + PW'(2 ** (QUANT - 1));
        ones = OW'(prod >> QUANT);
    end

    // Set the first 'ones' positions of the Weyl sequence.
    always_comb begin
        bits = '0;
        for (int k = 0; k < BITSTREAM; k++) begin
            if (OW'(k) < ones) begin
                bits[BW'((BASE + k * STRIDE) % BITSTREAM)] = 1'b1;
            end
        end
    end
endmodule

// Handshake: a result transfers on any rising edge where oValid && iReady.
// While oValid && !iReady the output fields are held stable. A requester
// holds iReq[i] (with stable data) until oAck[i]; oAck is combinational and
// fires only in the cycle the sample is captured.
module sng_rr_scheduler #(
    parameter int NREQ      = 4,
    parameter int BITSTREAM = 64,
    parameter int BASE      = 2,
    parameter int STRIDE    = 17,
    parameter int QUANT     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              iReq,
    input  logic [NREQ*QUANT-1:0]        iData,
    output logic [NREQ-1:0]              oAck,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [BITSTREAM-1:0]         oBitstream,
    output logic [$clog2(NREQ)-1:0]      oId,
    output logic [$clog2(BITSTREAM):0]   oOnes,
    output logic [$clog2(NREQ)-1:0]      dbg_ptr
);
    localparam int IDW = $clog2(NREQ);
    localparam int OW  = $clog2(BITSTREAM) + 1;

    function automatic int gcd_f(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    localparam int STRIDE_GCD = gcd_f(STRIDE, BITSTREAM);

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        return IDW'((int'(a) + b) % NREQ);
    endfunction

    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       grant;
    logic                 any_req;
    logic                 free;
    logic                 accept;
    logic [QUANT-1:0]     sample;
    logic [BITSTREAM-1:0] sng_bits;
    logic [OW-1:0]        sng_ones;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && iReq[wrap_add(ptr, k)]) begin
                any_req = 1'b1;
                grant   = wrap_add(ptr, k);
            end
        end
    end

    // Slot is free when empty or being drained this cycle; ack the winner.
    always_comb begin
        free   = !oValid || iReady;
        accept = free && any_req;
        oAck   = '0;
        if (accept) begin
            oAck[grant] = 1'b1;
        end
        sample = iData[int'(grant) * QUANT +: QUANT];
    end

    sng_weyl #(
        .BITSTREAM (BITSTREAM),
        .BASE      (BASE),
        .STRIDE    (STRIDE),
        .QUANT     (QUANT)
    ) u_sng (
        .sample (sample),
        .bits   (sng_bits),
        .ones   (sng_ones)
    );

    // Output register and pointer: reload on accept, clear valid on a bare drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid     <= 1'b0;
            oBitstream <= '0;
            oId        <= '0;
            oOnes      <= '0;
            ptr        <= '0;
        end else if (accept) begin
            oValid     <= 1'b1;
            oBitstream <= sng_bits;
            oId        <= grant;
            oOnes      <= sng_ones;
            ptr        <= wrap_add(grant, 1);
        end else if (iReady) begin
            oValid     <= 1'b0;
        end
    end

    assign dbg_ptr = ptr;

    // A non-coprime stride would revisit positions and lose ones.
    a_stride_coprime: assert property (@(posedge clk) STRIDE_GCD == 1);

    // Held result must not move under backpressure.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (oValid && !iReady) |=> (oValid && $stable(oBitstream) && $stable(oId) && $stable(oOnes)));

    // At most one ack per cycle.
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(oAck));
endmodule

// File: doc/sng_rr_scheduler.md
Name: sng_rr_scheduler

Overview:
- Shares one combinational SNG instance among NREQ requesters using round-robin arbitration.
- Each accepted sample (signed QUANT-bit) becomes a registered BITSTREAM-bit Weyl bitstream, tagged with the requester ID and the ones-count.
- The result sits in a single-entry output register with a valid/ready handshake.
- Sits between the per-channel quantised operand sources and the stochastic compute lanes.

Parameters:
- NREQ, 4, number of requesters (>=2).
- BITSTREAM, 64, bitstream length; passed to SNG.
- BASE, 2, first Weyl index; passed to SNG.
- STRIDE, 17, Weyl stride; passed to SNG. Must be coprime with BITSTREAM; an SVA in the RTL checks this.
- QUANT, 8, input sample width in bits (two's complement).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iReq  in  NREQ  per-requester request. Held high until acked.
- iData  in  NREQ*QUANT  packed signed samples; requester i occupies bits [i*QUANT +: QUANT].
- oAck  out  NREQ  one-hot, combinational. High in the cycle requester i's sample is accepted.
- oValid  out  1  output register holds a result.
- iReady  in  1  downstream accepts the result.
- oBitstream  out  BITSTREAM  registered SNG output.
- oId  out  $clog2(NREQ)  requester index of the result.
- oOnes  out  $clog2(BITSTREAM)+1  ones-count s of the result.

Behaviour:
- Reset (async assert, sync release): oValid=0, oBitstream=0, oId=0, oOnes=0, round-robin pointer ptr=0. oAck is combinationally 0 while oValid=0 and iReq=0.
- Slot free: free = !oValid || iReady.
- Accept condition: accept = free && |iReq.
- Grant selection: g = the first i with iReq[i]=1, scanning ptr, ptr+1, ... mod NREQ.
- oAck[g]=1 only when accept; all other oAck bits are 0.
- Mux: iData slice g drives the SNG iData input; the SNG output is combinational.
- On accept, at the next edge:
  - oBitstream <= SNG output
  - oId <= g
  - oOnes <= s
  - oValid <= 1
  - ptr <= (g+1) mod NREQ
- On oValid && iReady && !accept, at the next edge: oValid <= 0. All other registers hold.
- No accept and no drain: all registers hold. ptr changes only on accept.
- Latency: 1 cycle from ack to oValid. Throughput is 1 result per cycle while iReady=1.
- Backpressure: while oValid=1 and iReady=0:
  - no ack
  - oBitstream, oId and oOnes are stable
  - requesters keep iReq asserted
- Simultaneous drain and accept (oValid=1, iReady=1, request pending): the register reloads in the same edge and oValid stays 1.
- Fairness: a continuously asserted request is acked within NREQ accepts.
- ones-count arithmetic, in unsigned widths wide enough to hold the intermediate:
  - u = q + 2^(QUANT-1), range 0..2^QUANT-1
  - s = (u*BITSTREAM + 2^(QUANT-1)) >> QUANT
- s range at defaults: 0..64. oOnes must equal popcount(oBitstream).
- Bitstream shape: bit positions set are BASE + k*STRIDE mod BITSTREAM, for k = 0..s-1.
- Async reset mid-operation: any pending result is discarded immediately and oValid drops without a handshake. Requesters re-present after reset.
- Requester protocol: iData[i] must be stable while iReq[i]=1. Dropping iReq before ack is legal; that request is simply not served.

Test Plan:
- Reset: assert rst_n=0 mid-stream with oValid=1 -> oValid, oId and oOnes read 0 immediately, and ptr=0. After release, iReq=4'b1111 acks requester 0 first.
- Single request: iReq=4'b0100, iData[2]=0, iReady=1 -> oAck=4'b0100 that cycle. Next cycle: oValid=1, oId=2, oOnes=32, bits 2,19,36,53,6,… set (32 ones).
- Endpoints: q=-128 -> oOnes=0, oBitstream=0. q=127 -> oOnes=64, oBitstream all ones. Sweep all 256 q through requester 1 and compare against a Weyl reference model each cycle.
- Round-robin: iReq=4'b1111 held, iReady=1 -> ack order 0,1,2,3,0,… with one result per cycle. Then iReq=4'b1010 -> order alternates 1,3.
- Backpressure: oValid=1, iReady=0 for 5 cycles with iReq=4'b0001 -> no oAck and outputs stable. When iReady rises, the drain and the new accept happen in the same edge, and oValid stays 1 with the new oId.
- Bubble: a single accept followed by iReady=1 and iReq=0 -> oValid falls after one cycle, and ptr keeps its advanced value.
